// File: rtl/r5p_tcb_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate between REQ_N managers, with fixed-delay response routing.
// Optional bus locking for atomic sequences is built when R5P_TCB_ARB_LOCK_EN is defined.
module r5p_tcb_arbiter #(
  parameter int unsigned REQ_N = 2,
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32,
  parameter int unsigned DLY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_N-1:0]         req_vld,
  input  logic [REQ_N-1:0]         req_wen,
  input  logic [REQ_N-1:0]         req_ren,
  input  logic [REQ_N-1:0]         req_lck,
  input  logic [REQ_N*ADR_W-1:0]   req_adr,
  input  logic [REQ_N*2-1:0]       req_siz,
  input  logic [REQ_N*DAT_W-1:0]   req_wdt,
  output logic [REQ_N-1:0]         req_rdy,
  output logic [REQ_N-1:0]         rsp_vld,
  output logic [DAT_W-1:0]         rsp_rdt,
  output logic                     rsp_err,
  output logic                     man_vld,
  output logic                     man_wen,
  output logic                     man_ren,
  output logic                     man_lck,
  output logic [ADR_W-1:0]         man_adr,
  output logic [1:0]               man_siz,
  output logic [DAT_W-1:0]         man_wdt,
  input  logic                     man_rdy,
  input  logic [DAT_W-1:0]         man_rdt,
  input  logic                     man_err
);

  localparam int unsigned IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  function automatic logic [REQ_N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_N-1:0] oh;
    oh = '0;
    for (int i = 0; i < REQ_N; i++) oh[i] = (IDX_W'(i) == idx);
    return oh;
  endfunction

  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] gidx;
  logic             gsel;
  logic [REQ_N-1:0] gnt;
  logic             xfer;

`ifdef R5P_TCB_ARB_LOCK_EN
  typedef enum logic [0:0] {ARB, LOCK} state_t;
  state_t           state, state_nx;
  logic [IDX_W-1:0] lck_own, lck_own_nx;
`else
  logic unused_lck;
  assign unused_lck = ^req_lck;
`endif

  // Two passes give the rotated priority order ptr+1 .. REQ_N-1, 0 .. ptr.
  always_comb begin
    gsel = 1'b0;
    gidx = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!gsel && req_vld[i] && (IDX_W'(i) > ptr)) begin
        gsel = 1'b1;
        gidx = IDX_W'(i);
      end
    end
    for (int i = 0; i < REQ_N; i++) begin
      if (!gsel && req_vld[i] && (IDX_W'(i) <= ptr)) begin
        gsel = 1'b1;
        gidx = IDX_W'(i);
      end
    end
`ifdef R5P_TCB_ARB_LOCK_EN
    if (state == LOCK) begin
      gsel = 1'b1;
      gidx = lck_own;
    end
`endif
  end

  assign gnt     = gsel ? onehot(gidx) : '0;
  assign req_rdy = gnt & {REQ_N{man_rdy}};

  always_comb begin
    man_vld = |(req_vld & gnt);
    man_wen = 1'b0;
    man_ren = 1'b0;
    man_lck = 1'b0;
    man_adr = '0;
    man_siz = '0;
    man_wdt = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (gnt[i]) begin
        man_wen = man_wen | req_wen[i];
        man_ren = man_ren | req_ren[i];
`ifdef R5P_TCB_ARB_LOCK_EN
        man_lck = man_lck | req_lck[i];
`endif
        man_adr = man_adr | req_adr[i*ADR_W +: ADR_W];
        man_siz = man_siz | req_siz[i*2 +: 2];
        man_wdt = man_wdt | req_wdt[i*DAT_W +: DAT_W];
      end
    end
  end

  assign xfer = man_vld & man_rdy;

`ifdef R5P_TCB_ARB_LOCK_EN
  always_comb begin
    state_nx   = state;
    lck_own_nx = lck_own;
    ptr_nx     = ptr;
    case (state)
      ARB: begin
        if (xfer) begin
          ptr_nx = gidx;
          if (man_lck) begin
            state_nx   = LOCK;
            lck_own_nx = gidx;
          end
        end
      end
      LOCK: begin
        // Only lck_own can be granted here, so any unlocked transfer is its release.
        if (xfer && !man_lck) begin
          state_nx = ARB;
          ptr_nx   = lck_own;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ARB;
      lck_own <= '0;
    end else begin
      state   <= state_nx;
      lck_own <= lck_own_nx;
    end
  end
`else
  always_comb begin
    ptr_nx = ptr;
    if (xfer) ptr_nx = gidx;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) ptr <= IDX_W'(REQ_N-1);
    else      ptr <= ptr_nx;
  end

  // Response pipeline: stage 0 captures {transfer, owner}, stage DLY-1 is the response cycle.
  logic [DLY-1:0]   vld_p;
  logic [IDX_W-1:0] own_p [DLY];

  always_ff @(posedge clk) begin
    if (!rst) vld_p <= '0;
    else begin
      vld_p[0] <= xfer;
      for (int i = 1; i < DLY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    own_p[0] <= gidx;
    for (int i = 1; i < DLY; i++) own_p[i] <= own_p[i-1];
  end

  assign rsp_vld = vld_p[DLY-1] ? onehot(own_p[DLY-1]) : '0;
  assign rsp_rdt = man_rdt;
  assign rsp_err = man_err;

endmodule

// File: tb/tb_r5p_tcb_arbiter.sv
// Directed bench for r5p_tcb_arbiter with two requesters and a two-cycle response delay.
module tb_r5p_tcb_arbiter;

  localparam int unsigned REQ_N = 2;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned DLY   = 2;
`ifdef R5P_TCB_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [REQ_N-1:0]       req_vld, req_wen, req_ren, req_lck;
  logic [REQ_N*ADR_W-1:0] req_adr;
  logic [REQ_N*2-1:0]     req_siz;
  logic [REQ_N*DAT_W-1:0] req_wdt;
  logic [REQ_N-1:0]       req_rdy, rsp_vld;
  logic [DAT_W-1:0]       rsp_rdt;
  logic                   rsp_err;
  logic                   man_vld, man_wen, man_ren, man_lck;
  logic [ADR_W-1:0]       man_adr;
  logic [1:0]             man_siz;
  logic [DAT_W-1:0]       man_wdt;
  logic                   man_rdy;
  logic [DAT_W-1:0]       man_rdt;
  logic                   man_err;

  int tests = 0;
  int fails = 0;

  r5p_tcb_arbiter #(.REQ_N(REQ_N), .ADR_W(ADR_W), .DAT_W(DAT_W), .DLY(DLY)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_wen(req_wen), .req_ren(req_ren), .req_lck(req_lck),
    .req_adr(req_adr), .req_siz(req_siz), .req_wdt(req_wdt), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdt(rsp_rdt), .rsp_err(rsp_err),
    .man_vld(man_vld), .man_wen(man_wen), .man_ren(man_ren), .man_lck(man_lck),
    .man_adr(man_adr), .man_siz(man_siz), .man_wdt(man_wdt),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_vld = '0;
    req_wen = '0;
    req_ren = '0;
    req_lck = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    req_adr = '0;
    req_siz = '0;
    req_wdt = '0;
    man_rdy = 1'b1;
    man_rdt = '0;
    man_err = 1'b0;
    repeat (3) tick();
    #1;
    check("reset_rsp_vld", rsp_vld, 2'b00);
    check("reset_man_vld", man_vld, 1'b0);
    rst = 1'b1;
    tick(); #1;
    check("idle_rsp_vld", rsp_vld, 2'b00);
    check("idle_man_vld", man_vld, 1'b0);
    check("idle_req_rdy", req_rdy, 2'b00);
    check("idle_man_adr", man_adr, 32'h0);

    // Single read from requester 1
    tick();
    req_vld = 2'b10; req_ren = 2'b10;
    req_adr[32 +: 32] = 32'h8000_0010;
    req_siz[2 +: 2] = 2'd2;
    #1;
    check("rd1_man_vld", man_vld, 1'b1);
    check("rd1_man_adr", man_adr, 32'h8000_0010);
    check("rd1_man_ren", man_ren, 1'b1);
    check("rd1_man_wen", man_wen, 1'b0);
    check("rd1_man_siz", man_siz, 2'd2);
    check("rd1_req_rdy", req_rdy, 2'b10);
    tick(); idle(); #1;
    check("rd1_rsp_early", rsp_vld, 2'b00);
    tick(); man_rdt = 32'hDEAD_BEEF; #1;
    check("rd1_rsp_vld", rsp_vld, 2'b10);
    check("rd1_rsp_rdt", rsp_rdt, 32'hDEAD_BEEF);
    tick(); man_rdt = '0; #1;
    check("rd1_rsp_done", rsp_vld, 2'b00);

    // Both requesting continuously: grants alternate 0,1,0,1
    req_adr[0 +: 32]  = 32'h100;
    req_adr[32 +: 32] = 32'h200;
    tick(); req_vld = 2'b11; req_ren = 2'b11; #1;
    check("rr_c0_adr", man_adr, 32'h100);
    check("rr_c0_rsp", rsp_vld, 2'b00);
    tick(); #1;
    check("rr_c1_adr", man_adr, 32'h200);
    check("rr_c1_rsp", rsp_vld, 2'b00);
    tick(); #1;
    check("rr_c2_adr", man_adr, 32'h100);
    check("rr_c2_rsp", rsp_vld, 2'b01);
    tick(); #1;
    check("rr_c3_adr", man_adr, 32'h200);
    check("rr_c3_rsp", rsp_vld, 2'b10);
    tick(); idle(); #1;
    check("rr_c4_man_vld", man_vld, 1'b0);
    check("rr_c4_rsp", rsp_vld, 2'b01);
    tick(); #1;
    check("rr_c5_rsp", rsp_vld, 2'b10);
    tick(); #1;
    check("rr_c6_rsp", rsp_vld, 2'b00);

    // Stall: requester 0 keeps the grant while man_rdy is low
    tick(); man_rdy = 1'b0; req_vld = 2'b11; req_ren = 2'b11; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick(); #1; end
      check("stall_man_adr", man_adr, 32'h100);
      check("stall_req_rdy", req_rdy, 2'b00);
      check("stall_rsp", rsp_vld, 2'b00);
    end
    tick(); man_rdy = 1'b1; #1;
    check("stall_rel_adr", man_adr, 32'h100);
    check("stall_rel_rdy", req_rdy, 2'b01);
    tick(); req_vld = 2'b10; req_ren = 2'b10; #1;
    check("stall_r1_adr", man_adr, 32'h200);
    check("stall_r1_rdy", req_rdy, 2'b10);
    tick(); idle(); #1;
    check("stall_rsp0", rsp_vld, 2'b01);
    tick(); #1;
    check("stall_rsp1", rsp_vld, 2'b10);
    tick(); #1;
    check("stall_rsp_done", rsp_vld, 2'b00);

    // Locked sequence from requester 1 with requester 0 competing
    tick(); req_vld = 2'b10; req_ren = 2'b10; req_lck = 2'b10; #1;
    check("lck_c0_adr", man_adr, 32'h200);
    check("lck_c0_man_lck", man_lck, LOCK_EN ? 1'b1 : 1'b0);
    tick(); req_vld = 2'b11; req_ren = 2'b11; #1;
    check("lck_c1_adr", man_adr, LOCK_EN ? 32'h200 : 32'h100);
    check("lck_c1_man_lck", man_lck, LOCK_EN ? 1'b1 : 1'b0);
    tick(); req_lck = 2'b00; #1;
    check("lck_c2_adr", man_adr, 32'h200);
    check("lck_c2_man_lck", man_lck, 1'b0);
    tick(); #1;
    check("lck_c3_adr", man_adr, 32'h100);
    tick(); idle();
    tick(); tick(); #1;
    check("lck_drain_rsp", rsp_vld, 2'b00);

    // Reset pulsed one cycle after a read from requester 0
    tick(); req_vld = 2'b01; req_ren = 2'b01; #1;
    check("rst_rd_adr", man_adr, 32'h100);
    check("rst_rd_rdy", req_rdy, 2'b01);
    tick(); idle(); rst = 1'b0; #1;
    check("rst_rsp_a", rsp_vld, 2'b00);
    tick(); rst = 1'b1; #1;
    check("rst_rsp_dropped", rsp_vld, 2'b00);
    tick(); req_vld = 2'b11; req_ren = 2'b11; #1;
    check("rst_first_adr", man_adr, 32'h100);
    check("rst_first_rdy", req_rdy, 2'b01);
    tick(); idle(); #1;
    check("rst_rsp_b", rsp_vld, 2'b00);
    tick(); #1;
    check("rst_post_rsp", rsp_vld, 2'b01);
    tick(); #1;
    check("rst_post_done", rsp_vld, 2'b00);

    // Write from requester 1 answered with an error
    tick(); req_vld = 2'b10; req_wen = 2'b10;
    req_wdt[32 +: 32] = 32'h1234_5678;
    req_siz[2 +: 2] = 2'd1;
    #1;
    check("wr_man_wen", man_wen, 1'b1);
    check("wr_man_ren", man_ren, 1'b0);
    check("wr_man_wdt", man_wdt, 32'h1234_5678);
    check("wr_man_siz", man_siz, 2'd1);
    check("wr_req_rdy", req_rdy, 2'b10);
    tick(); idle(); #1;
    check("wr_rsp_early", rsp_vld, 2'b00);
    check("wr_err_early", rsp_err, 1'b0);
    tick(); man_err = 1'b1; #1;
    check("wr_rsp_vld", rsp_vld, 2'b10);
    check("wr_rsp_err", rsp_err, 1'b1);
    tick(); man_err = 1'b0; #1;
    check("wr_rsp_done", rsp_vld, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
